// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC/nPC with branch delay slot, imem wait handling, IF/ID register.
// Optional perf counters are built only when IF_PERF_COUNTERS_EN is defined.
module if_stage_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_enable,
   input  logic        load_enable,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid,
   output logic        fetch_stall,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_cycles
);

   typedef enum logic [0:0] {StFetch, StWait} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, npc_q;
   logic        pend_valid_q;
   logic [31:0] pend_target_q;
   logic [31:0] instr_q, ipc_q;
   logic        ivalid_q;

   logic        adv;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] npc_next;

   // ---------------- fetch FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: if (imem_req && !imem_ready) state_d = StWait;
         StWait:  if (imem_ready)              state_d = StFetch;
         default: state_d = StFetch;
      endcase
   end

   // Request is issued in both states; only reset suppresses it.
   always_comb begin
      imem_req = 1'b0;
      unique case (state_q)
         StFetch: imem_req = ~reset;
         StWait:  imem_req = ~reset;
         default: imem_req = 1'b0;
      endcase
      imem_addr   = pc_q;
      fetch_stall = imem_req & ~imem_ready;
   end

   // ---------------- PC / redirect ----------------
   always_comb begin
      adv      = pc_enable & imem_req & imem_ready;
      redirect = branch_taken | pend_valid_q;
      target   = branch_taken ? branch_target : pend_target_q;
      npc_next = redirect ? target : npc_q + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         npc_q         <= RESET_PC + 32'd4;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'h0;
      end else if (adv) begin
         pc_q         <= npc_q;
         npc_q        <= npc_next;
         pend_valid_q <= 1'b0;
      end else if (branch_taken) begin
         // Branch resolved while fetch is blocked: remember it until the next advance.
         pend_valid_q  <= 1'b1;
         pend_target_q <= branch_target;
      end
   end

   // ---------------- IF/ID register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q  <= 32'h0;
         ipc_q    <= 32'h0;
         ivalid_q <= 1'b0;
      end else if (load_enable) begin
         if (adv) begin
            instr_q  <= imem_data;
            ipc_q    <= pc_q;
            ivalid_q <= 1'b1;
         end else begin
            instr_q  <= 32'h0;
            ivalid_q <= 1'b0;
         end
      end
   end

   assign if_id_instr = instr_q;
   assign if_id_pc    = ipc_q;
   assign if_id_valid = ivalid_q;

   // ---------------- perf counters ----------------
`ifdef IF_PERF_COUNTERS_EN
   logic [31:0] fetch_count_q, stall_cycles_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count_q  <= 32'h0;
         stall_cycles_q <= 32'h0;
      end else begin
         if (adv)         fetch_count_q  <= fetch_count_q + 32'd1;
         if (fetch_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
      end
   end

   assign fetch_count  = fetch_count_q;
   assign stall_cycles = stall_cycles_q;
`else
   assign fetch_count  = 32'h0;
   assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Scoreboard bench for if_stage_unit: directed test-plan sequences then random traffic,
// checked each cycle against a program-counter reference model.
module tb_if_stage_unit;

   localparam logic [31:0] RP = 32'h100;

   logic        clk = 1'b0;
   logic        reset, pc_enable, load_enable, branch_taken, imem_ready;
   logic [31:0] branch_target, imem_data;
   logic        imem_req, if_id_valid, fetch_stall;
   logic [31:0] imem_addr, if_id_instr, if_id_pc, fetch_count, stall_cycles;

   always #5 clk = ~clk;

   if_stage_unit #(.RESET_PC(RP)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_enable    (pc_enable),
      .load_enable  (load_enable),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_data    (imem_data),
      .if_id_instr  (if_id_instr),
      .if_id_pc     (if_id_pc),
      .if_id_valid  (if_id_valid),
      .fetch_stall  (fetch_stall),
      .fetch_count  (fetch_count),
      .stall_cycles (stall_cycles)
   );

   typedef struct {
      logic        req;
      logic        stall;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        ivalid;
      logic [31:0] fc;
      logic [31:0] sc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: architectural fetch state.
   bit          m_known = 0;
   logic [31:0] m_pc, m_npc, m_ptgt, m_instr, m_ipc, m_fc, m_sc;
   logic        m_pend, m_ivalid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cycle(input logic rst, input logic pe, input logic le, input logic bt,
                        input logic [31:0] tgt, input logic rdy, input logic [31:0] data);
      exp_t e;
      logic adv;
      @(posedge clk);
      #1;
      reset = rst; pc_enable = pe; load_enable = le; branch_taken = bt;
      branch_target = tgt; imem_ready = rdy; imem_data = data;
      if (m_known) begin
         e.req    = ~rst;
         e.stall  = ~rst & ~rdy;
         e.addr   = m_pc;
         e.instr  = m_instr;
         e.ipc    = m_ipc;
         e.ivalid = m_ivalid;
`ifdef IF_PERF_COUNTERS_EN
         e.fc = m_fc;
         e.sc = m_sc;
`else
         e.fc = 32'h0;
         e.sc = 32'h0;
`endif
         q.push_back(e);
      end
      if (rst) begin
         m_pc = RP; m_npc = RP + 32'd4; m_pend = 0; m_ptgt = 0;
         m_instr = 0; m_ipc = 0; m_ivalid = 0; m_fc = 0; m_sc = 0;
         m_known = 1;
      end else begin
         adv = pe & rdy;
         if (!rdy) m_sc = m_sc + 1;
         if (le) begin
            if (adv) begin m_instr = data; m_ipc = m_pc; m_ivalid = 1; end
            else     begin m_instr = 0; m_ivalid = 0; end
         end
         if (adv) begin
            m_fc  = m_fc + 1;
            m_pc  = m_npc;
            m_npc = bt ? tgt : (m_pend ? m_ptgt : m_npc + 32'd4);
            m_pend = 0;
         end else if (bt) begin
            m_pend = 1;
            m_ptgt = tgt;
         end
      end
   endtask

   // Monitor: outputs have settled by the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("imem_req",     {31'h0, imem_req},    {31'h0, e.req});
         check("fetch_stall",  {31'h0, fetch_stall}, {31'h0, e.stall});
         check("imem_addr",    imem_addr,            e.addr);
         check("if_id_instr",  if_id_instr,          e.instr);
         check("if_id_pc",     if_id_pc,             e.ipc);
         check("if_id_valid",  {31'h0, if_id_valid}, {31'h0, e.ivalid});
         check("fetch_count",  fetch_count,          e.fc);
         check("stall_cycles", stall_cycles,         e.sc);
      end
   end

   initial begin
      reset = 1; pc_enable = 0; load_enable = 0; branch_taken = 0;
      branch_target = 0; imem_ready = 0; imem_data = 0;

      // Reset, then sequential fetch with a hazard stall at 108.
      repeat (2) cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 1, 32'hA000_0100);
      cycle(0, 1, 1, 0, 0, 1, 32'hA000_0104);
      repeat (2) cycle(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      cycle(0, 1, 1, 0, 0, 1, 32'hA000_0108);
      cycle(0, 1, 1, 0, 0, 1, 32'hA000_010C);

      // Delay slot: taken branch while IF is at 104.
      repeat (2) cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 1, 32'hB000_0100);
      cycle(0, 1, 1, 1, 32'h200, 1, 32'hB000_0104);
      cycle(0, 1, 1, 0, 0, 1, 32'hB000_0108);
      cycle(0, 1, 1, 0, 0, 1, 32'hB000_0200);

      // Branch during a 3-cycle memory wait, redirect buffered until ready returns.
      cycle(0, 1, 1, 1, 32'h300, 0, 32'h0);
      repeat (2) cycle(0, 1, 1, 0, 0, 0, 32'h0);
      cycle(0, 1, 1, 0, 0, 1, 32'hC000_0204);
      @(negedge clk);
`ifdef IF_PERF_COUNTERS_EN
      check("stall_after_wait", stall_cycles, 32'd3);
`else
      check("stall_after_wait", stall_cycles, 32'd0);
`endif
      cycle(0, 1, 1, 0, 0, 1, 32'hC000_0208);
      cycle(0, 1, 1, 0, 0, 1, 32'hC000_0300);
      cycle(0, 1, 1, 0, 0, 1, 32'hC000_0304);

      // Reset in the middle of a wait with a redirect pending.
      cycle(0, 1, 1, 1, 32'h400, 0, 32'h0);
      cycle(1, 1, 1, 0, 0, 0, 32'h0);
      repeat (3) cycle(0, 1, 1, 0, 0, 1, $urandom);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(99) < 2),
               ($urandom_range(99) < 80),
               ($urandom_range(99) < 80),
               ($urandom_range(99) < 15),
               $urandom,
               ($urandom_range(99) < 70),
               $urandom);
      end

      cycle(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
